// File: rtl/mlaccel_memcopy.sv
`default_nettype none
// mlaccel_memcopy: chunked read-burst / write-burst DMA initiator for the 64-bit memory port.
// Define MLACCEL_MEMCOPY_FILL_EN to compile in pattern-fill commands.
module mlaccel_memcopy #(
    parameter int BUF_DEPTH    = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_src,
    input  logic [15:0] cmd_dst,
    input  logic [11:0] cmd_len,
    input  logic        cmd_fill,
    input  logic [63:0] cmd_fill_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wen,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic        done
);
    localparam int IDX_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = 5;
    localparam int WAIT_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t              state, state_next;
    logic [15:0]         src_ptr, dst_ptr, addr_hold;
    logic [63:0]         wdata_hold;
    logic [11:0]         remaining;
    logic [CNT_W-1:0]    chunk, cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                last_in_chunk, wait_last;
    logic [63:0]         buffer [BUF_DEPTH];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [IDX_W-1:0]    pipe_tag [READ_LATENCY];
    logic                fill_mode, fill_req;
    logic [63:0]         fill_data;

`ifdef MLACCEL_MEMCOPY_FILL_EN
    assign fill_req = cmd_fill;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fill_mode <= 1'b0;
            fill_data <= '0;
        end else if (state == IDLE && cmd_valid) begin
            fill_mode <= cmd_fill;
            fill_data <= cmd_fill_data;
        end
    end
`else
    logic unused_fill;
    assign fill_req    = 1'b0;
    assign fill_mode   = 1'b0;
    assign fill_data   = '0;
    assign unused_fill = ^{cmd_fill, cmd_fill_data};
`endif

    function automatic logic [CNT_W-1:0] chunk_of(input logic [11:0] n);
        return (n >= 12'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH) : n[CNT_W-1:0];
    endfunction

    assign last_in_chunk = (cnt == chunk - CNT_W'(1));
    assign wait_last     = (wait_cnt == WAIT_W'(READ_LATENCY - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_wen    = 8'h00;
        mem_addr   = addr_hold;
        mem_wdata  = wdata_hold;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == 12'd0) state_next = DONE;
                    else if (fill_req)    state_next = WRITE;
                    else                  state_next = READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = src_ptr;
                if (last_in_chunk) state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_last) state_next = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_wen   = 8'hFF;
                mem_addr  = dst_ptr;
                mem_wdata = fill_mode ? fill_data : buffer[cnt[IDX_W-1:0]];
                if (fill_mode) begin
                    if (remaining == 12'd1) state_next = DONE;
                end else if (last_in_chunk) begin
                    state_next = (remaining == 12'd0) ? DONE : READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Copy mode counts transfers down as reads issue; fill mode counts them as writes issue.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            src_ptr    <= '0;
            dst_ptr    <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            remaining  <= '0;
            chunk      <= '0;
            cnt        <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    src_ptr   <= cmd_src;
                    dst_ptr   <= cmd_dst;
                    remaining <= cmd_len;
                    chunk     <= chunk_of(cmd_len);
                    cnt       <= '0;
                    wait_cnt  <= '0;
                end
                READ: begin
                    src_ptr   <= src_ptr + 16'd4;
                    addr_hold <= src_ptr;
                    remaining <= remaining - 12'd1;
                    cnt       <= last_in_chunk ? '0 : cnt + CNT_W'(1);
                end
                WAIT: wait_cnt <= wait_last ? '0 : wait_cnt + WAIT_W'(1);
                WRITE: begin
                    dst_ptr    <= dst_ptr + 16'd4;
                    addr_hold  <= dst_ptr;
                    wdata_hold <= mem_wdata;
                    if (fill_mode) begin
                        remaining <= remaining - 12'd1;
                    end else if (last_in_chunk) begin
                        cnt   <= '0;
                        chunk <= chunk_of(remaining);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_valid[0] <= (state == READ);
            pipe_tag[0]   <= cnt[IDX_W-1:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (pipe_valid[READ_LATENCY-1]) buffer[pipe_tag[READ_LATENCY-1]] <= mem_rdata;
    end
endmodule
`default_nettype wire

// File: tb/tb_mlaccel_memcopy.sv
`default_nettype none
// tb_mlaccel_memcopy: directed checks of mlaccel_memcopy against a 16-bit-word memory model.
module tb_mlaccel_memcopy;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_src = '0;
    logic [15:0] cmd_dst = '0;
    logic [11:0] cmd_len = '0;
    logic        cmd_fill = 1'b0;
    logic [63:0] cmd_fill_data = '0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wen;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;
    logic        done;

    mlaccel_memcopy #(.BUF_DEPTH(4), .READ_LATENCY(2)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_fill(cmd_fill), .cmd_fill_data(cmd_fill_data),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Memory of 16-bit words; a 64-bit access covers four consecutive (wrapping) addresses.
    logic [15:0] mem [65536];
    logic [63:0] rd_stage;

    function automatic logic [63:0] rd64(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    always @(posedge clock) begin
        mem_rdata <= rd_stage;
        rd_stage  <= rd64(mem_addr);
        if (mem_wen == 8'hFF) begin
            mem[mem_addr]         = mem_wdata[15:0];
            mem[mem_addr + 16'd1] = mem_wdata[31:16];
            mem[mem_addr + 16'd2] = mem_wdata[47:32];
            mem[mem_addr + 16'd3] = mem_wdata[63:48];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] addr_log  [256];
    logic [7:0]  wen_log   [256];
    logic [63:0] wdata_log [256];
    logic [63:0] exp_w     [16];
    int          done_cyc, nowrite_busy, bad_wen;

    task automatic snap(input logic [15:0] src, input int len);
        for (int i = 0; i < len; i++) exp_w[i] = rd64(src + 16'(4 * i));
    endtask

    task automatic start_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [11:0] len,
                             input logic fill, input logic [63:0] fdata);
        @(negedge clock);
        cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill; cmd_fill_data = fdata;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    // Cycle n is sampled on the falling edge after the n-th rising edge following acceptance.
    task automatic wait_done(input int budget);
        done_cyc = -1; nowrite_busy = 0; bad_wen = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            addr_log[n] = mem_addr; wen_log[n] = mem_wen; wdata_log[n] = mem_wdata;
            if (busy && mem_wen == 8'h00) nowrite_busy++;
            if (mem_wen != 8'h00 && !(busy && mem_wen == 8'hFF)) bad_wen++;
            if (done) begin
                done_cyc = n;
                break;
            end
        end
    endtask

    logic [63:0] pre0604;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'hC3A5;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_wen",       64'(mem_wen),   64'd0);
        chk("rst_addr",      64'(mem_addr),  64'd0);
        chk("rst_wdata",     mem_wdata,      64'd0);
        resetn = 1'b1;

        // Aligned single-word copy
        start_cmd(16'h0000, 16'h0100, 12'd1, 1'b0, 64'd0);
        wait_done(50);
        chk("t1_done_cyc",  64'(done_cyc),  64'd5);
        chk("t1_rd_addr",   64'(addr_log[1]), 64'h0000);
        chk("t1_rd_wen",    64'(wen_log[1]),  64'h00);
        chk("t1_wr_wen",    64'(wen_log[4]),  64'hFF);
        chk("t1_wr_addr",   64'(addr_log[4]), 64'h0100);
        chk("t1_wr_data",   wdata_log[4],     64'h4444_3333_2222_1111);
        chk("t1_mem",       rd64(16'h0100),   64'h4444_3333_2222_1111);
        chk("t1_bad_wen",   64'(bad_wen),     64'd0);

        // Unaligned three-chunk copy (4,4,1)
        snap(16'h0003, 9);
        start_cmd(16'h0003, 16'h0201, 12'd9, 1'b0, 64'd0);
        wait_done(100);
        chk("t2_done_cyc",  64'(done_cyc),     64'd25);
        chk("t2_rd1",       64'(addr_log[1]),  64'h0003);
        chk("t2_rd4",       64'(addr_log[4]),  64'h000F);
        chk("t2_wr1_addr",  64'(addr_log[7]),  64'h0201);
        chk("t2_wr1_wen",   64'(wen_log[7]),   64'hFF);
        chk("t2_rd5",       64'(addr_log[11]), 64'h0013);
        chk("t2_wr5",       64'(addr_log[17]), 64'h0211);
        chk("t2_rd9",       64'(addr_log[21]), 64'h0023);
        chk("t2_wr9",       64'(addr_log[24]), 64'h0221);
        chk("t2_nonwrite",  64'(nowrite_busy), 64'd15);
        for (int i = 0; i < 9; i++) chk($sformatf("t2_mem%0d", i), rd64(16'h0201 + 16'(4 * i)), exp_w[i]);

        // Source address wraps from 0xFFFC to 0x0000
        snap(16'hFFFC, 2);
        start_cmd(16'hFFFC, 16'h1000, 12'd2, 1'b0, 64'd0);
        wait_done(50);
        chk("t3_done_cyc",  64'(done_cyc),    64'd7);
        chk("t3_rd2_addr",  64'(addr_log[2]), 64'h0000);
        chk("t3_wr1_data",  wdata_log[5],     exp_w[0]);
        chk("t3_wr2_data",  wdata_log[6],     64'h4444_3333_2222_1111);
        chk("t3_mem0",      rd64(16'h1000),   exp_w[0]);
        chk("t3_mem1",      rd64(16'h1004),   64'h4444_3333_2222_1111);

        // len=0 followed by a command held valid
        snap(16'h0A00, 1);
        @(negedge clock);
        cmd_src = 16'h0C00; cmd_dst = 16'h0D00; cmd_len = 12'd0; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_src = 16'h0A00; cmd_dst = 16'h0B00; cmd_len = 12'd1;
        @(negedge clock);
        chk("t4_done",      64'(done),      64'd1);
        chk("t4_ready_dn",  64'(cmd_ready), 64'd0);
        chk("t4_wen_c1",    64'(mem_wen),   64'd0);
        chk("t4_busy_c1",   64'(busy),      64'd0);
        @(negedge clock);
        chk("t4_ready_c2",  64'(cmd_ready), 64'd1);
        chk("t4_done_c2",   64'(done),      64'd0);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        wait_done(50);
        chk("t4_b2b_done",  64'(done_cyc),  64'd5);
        chk("t4_b2b_mem",   rd64(16'h0B00), exp_w[0]);

        // Reset during the second write cycle
        pre0604 = rd64(16'h0604);
        start_cmd(16'h0500, 16'h0600, 12'd2, 1'b0, 64'd0);
        repeat (5) @(negedge clock);
        chk("t5_busy_pre",  64'(busy),     64'd1);
        @(negedge clock);
        chk("t5_wen_pre",   64'(mem_wen),  64'hFF);
        resetn = 1'b0;
        #1;
        chk("t5_wen_async", 64'(mem_wen),  64'h00);
        chk("t5_busy_rst",  64'(busy),     64'd0);
        chk("t5_done_rst",  64'(done),     64'd0);
        repeat (2) begin
            @(negedge clock);
            chk("t5_no_done", 64'(done), 64'd0);
        end
        chk("t5_aborted",   rd64(16'h0604), pre0604);
        resetn = 1'b1;
        snap(16'h0700, 1);
        start_cmd(16'h0700, 16'h0800, 12'd1, 1'b0, 64'd0);
        wait_done(50);
        chk("t5_after_done", 64'(done_cyc),  64'd5);
        chk("t5_after_mem",  rd64(16'h0800), exp_w[0]);

        // Fill command (copy when the fill feature is not built)
        snap(16'h0900, 5);
        start_cmd(16'h0900, 16'h0040, 12'd5, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        wait_done(80);
`ifdef MLACCEL_MEMCOPY_FILL_EN
        chk("t6_done_cyc",  64'(done_cyc),     64'd6);
        chk("t6_nonwrite",  64'(nowrite_busy), 64'd0);
        chk("t6_wr1_addr",  64'(addr_log[1]),  64'h0040);
        chk("t6_wr5_addr",  64'(addr_log[5]),  64'h0050);
        chk("t6_wr3_data",  wdata_log[3],      64'hDEAD_BEEF_CAFE_F00D);
        chk("t6_mem5",      rd64(16'h0050),    64'hDEAD_BEEF_CAFE_F00D);
`else
        chk("t6_done_cyc",  64'(done_cyc),     64'd15);
        chk("t6_nonwrite",  64'(nowrite_busy), 64'd9);
        for (int i = 0; i < 5; i++) chk($sformatf("t6_mem%0d", i), rd64(16'h0040 + 16'(4 * i)), exp_w[i]);
`endif
        chk("t6_bad_wen",   64'(bad_wen),      64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
